// File: rtl/regfile_write_arbiter_pkg.sv
// Shared processor constants for the register-file write arbiter.
// Widths, default requester count and pointer sizing helper.
package regfile_write_arbiter_pkg;

    localparam int NREQ_DEF = 3;
    localparam int DW_DEF   = 16;
    localparam int AW_DEF   = 3;
    localparam int NREGS    = 8;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester-side bundle: packed per-requester valid/addr/data with
// a one-hot ready returned by the arbiter.
interface regfile_write_arbiter_if
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin pick: search from ptr_i upward with wrap,
// first set request wins; returns one-hot grant plus its index.
module rr_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    localparam int PW   = ptr_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   gnt_idx_o,
    output logic            gnt_vld_o
);

    int j;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        j         = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr_i) + k) % NREQ;
            if (!gnt_vld_o && req_i[j]) begin
                gnt_vld_o = 1'b1;
                gnt_o[j]  = 1'b1;
                gnt_idx_o = PW'(j);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter merging several write requesters onto the single
// register-file write port, with a one-entry output stage and forwarding.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_write_arbiter_if.slave req,
    input  logic                  stall,
    output logic                  write,
    output logic [AW-1:0]         writeAdd,
    output logic [DW-1:0]         in,
    input  logic [AW-1:0]         readAdd1,
    input  logic [AW-1:0]         readAdd2,
    output logic                  fwd1_hit,
    output logic                  fwd2_hit,
    output logic [DW-1:0]         fwd_data
);

    localparam int PW = ptr_w(NREQ);

    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            wr_vld_q, wr_vld_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;

    logic [NREQ-1:0] arb_req;
    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   gnt_idx;
    logic            gnt_vld;

    // Holding the grant off during reset keeps req_ready low as well.
    assign arb_req = req.req_valid & {NREQ{~stall & reset}};

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req_i     (arb_req),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    assign req.req_ready = gnt;

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        wr_vld_d  = gnt_vld;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (gnt_vld) begin
            wr_addr_d = req.req_addr[int'(gnt_idx)*AW +: AW];
            wr_data_d = req.req_data[int'(gnt_idx)*DW +: DW];
            if (int'(gnt_idx) == NREQ - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gnt_idx + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q  <= '0;
            wr_vld_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wr_vld_q  <= wr_vld_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign write    = ~wr_vld_q;
    assign writeAdd = wr_addr_q;
    assign in       = wr_data_q;
    assign fwd_data = wr_data_q;
    assign fwd1_hit = wr_vld_q && (readAdd1 == wr_addr_q);
    assign fwd2_hit = wr_vld_q && (readAdd2 == wr_addr_q);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed vector bench for regfile_write_arbiter plus a hand-written
// reset-during-grant sequence.
module tb_regfile_write_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 16;
    localparam int AW   = 3;

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic [2:0]  valid;
        logic [2:0]  a0, a1, a2;
        logic [15:0] d0, d1, d2;
        logic [2:0]  rd1, rd2;
        logic [2:0]  e_rdy;
        logic        e_wr;
        logic [2:0]  e_wa;
        logic [15:0] e_in;
        logic        e_f1, e_f2;
    } vec_t;

    logic          clk;
    logic          reset;
    logic          stall;
    logic          write;
    logic [AW-1:0] writeAdd;
    logic [DW-1:0] in;
    logic [AW-1:0] readAdd1, readAdd2;
    logic          fwd1_hit, fwd2_hit;
    logic [DW-1:0] fwd_data;

    int n_tests;
    int n_fail;
    logic mon;
    logic saw_low;

    regfile_write_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    regfile_write_arbiter #(
        .NREQ (NREQ),
        .DW   (DW),
        .AW   (AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (bus),
        .stall    (stall),
        .write    (write),
        .writeAdd (writeAdd),
        .in       (in),
        .readAdd1 (readAdd1),
        .readAdd2 (readAdd2),
        .fwd1_hit (fwd1_hit),
        .fwd2_hit (fwd2_hit),
        .fwd_data (fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge write) if (mon) saw_low = 1'b1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic rst, input logic stl, input logic [2:0] v,
        input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2,
        input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
        input logic [2:0] r1, input logic [2:0] r2,
        input logic [2:0] rdy, input logic wr, input logic [2:0] wa,
        input logic [15:0] wd, input logic f1, input logic f2);
        vec_t t;
        t.rst = rst; t.stall = stl; t.valid = v;
        t.a0 = a0; t.a1 = a1; t.a2 = a2;
        t.d0 = d0; t.d1 = d1; t.d2 = d2;
        t.rd1 = r1; t.rd2 = r2;
        t.e_rdy = rdy; t.e_wr = wr; t.e_wa = wa; t.e_in = wd;
        t.e_f1 = f1; t.e_f2 = f2;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        reset         = t.rst;
        stall         = t.stall;
        bus.req_valid = t.valid;
        bus.req_addr  = {t.a2, t.a1, t.a0};
        bus.req_data  = {t.d2, t.d1, t.d0};
        readAdd1      = t.rd1;
        readAdd2      = t.rd2;
    endtask

    task automatic compare(input int i, input vec_t t);
        string s;
        s = $sformatf("v%0d", i);
        check({s, " ready"}, 32'(bus.req_ready), 32'(t.e_rdy));
        check({s, " write"}, 32'(write), 32'(t.e_wr));
        check({s, " writeAdd"}, 32'(writeAdd), 32'(t.e_wa));
        check({s, " in"}, 32'(in), 32'(t.e_in));
        check({s, " fwd_data"}, 32'(fwd_data), 32'(t.e_in));
        check({s, " fwd1"}, 32'(fwd1_hit), 32'(t.e_f1));
        check({s, " fwd2"}, 32'(fwd2_hit), 32'(t.e_f2));
    endtask

    vec_t vecs[20];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        mon     = 1'b0;
        saw_low = 1'b0;
        reset   = 1'b0;
        stall   = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        readAdd1 = '0;
        readAdd2 = '0;

        //        rst stl val  a0 a1 a2  d0       d1       d2       r1 r2  rdy  wr wa in       f1 f2
        vecs[0]  = mk(0, 0, 3'b111, 1, 2, 3, 16'h1111, 16'h2222, 16'h3333, 0, 0, 3'b000, 1, 0, 16'h0000, 0, 0);
        vecs[1]  = mk(1, 0, 3'b001, 5, 0, 0, 16'h1234, 16'h0000, 16'h0000, 5, 4, 3'b001, 1, 0, 16'h0000, 0, 0);
        vecs[2]  = mk(1, 0, 3'b000, 5, 0, 0, 16'h1234, 16'h0000, 16'h0000, 5, 4, 3'b000, 0, 5, 16'h1234, 1, 0);
        vecs[3]  = mk(1, 0, 3'b000, 5, 0, 0, 16'h1234, 16'h0000, 16'h0000, 5, 4, 3'b000, 1, 5, 16'h1234, 0, 0);
        vecs[4]  = mk(0, 0, 3'b000, 1, 2, 3, 16'h1111, 16'h2222, 16'h3333, 0, 0, 3'b000, 1, 0, 16'h0000, 0, 0);
        vecs[5]  = mk(1, 0, 3'b111, 1, 2, 3, 16'h1111, 16'h2222, 16'h3333, 0, 0, 3'b001, 1, 0, 16'h0000, 0, 0);
        vecs[6]  = mk(1, 0, 3'b111, 1, 2, 3, 16'h1111, 16'h2222, 16'h3333, 0, 0, 3'b010, 0, 1, 16'h1111, 0, 0);
        vecs[7]  = mk(1, 0, 3'b111, 1, 2, 3, 16'h1111, 16'h2222, 16'h3333, 0, 0, 3'b100, 0, 2, 16'h2222, 0, 0);
        vecs[8]  = mk(1, 0, 3'b111, 1, 2, 3, 16'h1111, 16'h2222, 16'h3333, 0, 0, 3'b001, 0, 3, 16'h3333, 0, 0);
        vecs[9]  = mk(1, 0, 3'b000, 1, 2, 3, 16'h1111, 16'h2222, 16'h3333, 0, 0, 3'b000, 0, 1, 16'h1111, 0, 0);
        vecs[10] = mk(1, 0, 3'b010, 0, 3, 0, 16'h0000, 16'hBEEF, 16'h0000, 0, 0, 3'b010, 1, 1, 16'h1111, 0, 0);
        vecs[11] = mk(1, 0, 3'b000, 0, 3, 0, 16'h0000, 16'hBEEF, 16'h0000, 3, 4, 3'b000, 0, 3, 16'hBEEF, 1, 0);
        vecs[12] = mk(1, 0, 3'b100, 0, 0, 6, 16'h0000, 16'h0000, 16'h5A5A, 3, 0, 3'b100, 1, 3, 16'hBEEF, 0, 0);
        vecs[13] = mk(1, 1, 3'b111, 0, 0, 6, 16'h0000, 16'h0000, 16'h5A5A, 6, 0, 3'b000, 0, 6, 16'h5A5A, 1, 0);
        vecs[14] = mk(1, 0, 3'b000, 0, 0, 6, 16'h0000, 16'h0000, 16'h5A5A, 6, 0, 3'b000, 1, 6, 16'h5A5A, 0, 0);
        vecs[15] = mk(1, 0, 3'b001, 0, 0, 0, 16'h0F0F, 16'h0000, 16'h0000, 0, 0, 3'b001, 1, 6, 16'h5A5A, 0, 0);
        vecs[16] = mk(1, 0, 3'b110, 0, 7, 7, 16'h0F0F, 16'h0001, 16'h0002, 7, 0, 3'b010, 0, 0, 16'h0F0F, 0, 1);
        vecs[17] = mk(1, 0, 3'b100, 0, 7, 7, 16'h0F0F, 16'h0001, 16'h0002, 7, 0, 3'b100, 0, 7, 16'h0001, 1, 0);
        vecs[18] = mk(1, 0, 3'b000, 0, 7, 7, 16'h0F0F, 16'h0001, 16'h0002, 7, 0, 3'b000, 0, 7, 16'h0002, 1, 0);
        vecs[19] = mk(1, 0, 3'b000, 0, 7, 7, 16'h0F0F, 16'h0001, 16'h0002, 7, 0, 3'b000, 1, 7, 16'h0002, 0, 0);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            compare(i, vecs[i]);
        end

        // Reset lands between a grant and the edge that would register it.
        @(negedge clk);
        bus.req_valid = 3'b001;
        bus.req_addr  = {3'd0, 3'd0, 3'd2};
        bus.req_data  = {16'h0000, 16'h0000, 16'h0101};
        #1;
        check("rst pre-grant ready", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid = 3'b010;
        bus.req_addr  = {3'd0, 3'd6, 3'd2};
        bus.req_data  = {16'h0000, 16'hAAAA, 16'h0101};
        #1;
        check("rst grant ready", 32'(bus.req_ready), 32'h2);
        check("rst prev write", 32'(write), 32'h0);
        #2;
        mon   = 1'b1;
        reset = 1'b0;
        #1;
        check("rst ready low", 32'(bus.req_ready), 32'h0);
        check("rst write high", 32'(write), 32'h1);
        check("rst writeAdd", 32'(writeAdd), 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check("rst hold write", 32'(write), 32'h1);
            check("rst hold in", 32'(in), 32'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        bus.req_valid = 3'b111;
        #1;
        check("rst release ready", 32'(bus.req_ready), 32'h1);
        check("rst release write", 32'(write), 32'h1);
        check("rst R6 never written", 32'(saw_low), 32'h0);
        mon = 1'b0;
        @(negedge clk);
        bus.req_valid = 3'b000;
        #1;
        check("post-rst write", 32'(write), 32'h0);
        check("post-rst writeAdd", 32'(writeAdd), 32'h2);
        check("post-rst in", 32'(in), 32'h0101);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3: number of write requesters, index 0..NREQ-1.
REQ-002 SHALL have parameter DW, default 16: register data width.
REQ-003 SHALL have parameter AW, default 3: register address width, addressing 8 registers.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid, input, NREQ: per-requester write request.
REQ-007 SHALL have port req_addr, input, NREQ*AW: per-requester destination register, packed, requester i at bits [i*AW +: AW].
REQ-008 SHALL have port req_data, input, NREQ*DW: per-requester write data, packed likewise.
REQ-009 SHALL have port req_ready, output, NREQ: one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both 1.
REQ-010 SHALL have port stall, input, 1: pipeline hold; no grants while 1.
REQ-011 SHALL have port write, output, 1: register-file write strobe, active-low.
REQ-012 SHALL have port writeAdd, output, AW: register-file write address.
REQ-013 SHALL have port in, output, DW: register-file write data.
REQ-014 SHALL have ports readAdd1 and readAdd2, input, AW each: register-file read addresses, used for forwarding.
REQ-015 SHALL have ports fwd1_hit and fwd2_hit, output, 1 each: the matching read address targets the in-flight write.
REQ-016 SHALL have port fwd_data, output, DW: equals the in port value; valid when fwd1_hit or fwd2_hit is 1.

Function
REQ-017 SHALL grant at most one requester per cycle, and only when stall is 0.
REQ-018 SHALL arbitrate round-robin: search starts at rr_ptr, ascending index with wrap from NREQ-1 to 0; first valid requester wins.
REQ-019 SHALL, on a grant to requester i, set rr_ptr to (i+1) mod NREQ at the next edge; rr_ptr SHALL be unchanged when no grant occurs.
REQ-020 SHALL assert req_ready combinationally in the same cycle as the request, with no dependence on req_data.
REQ-021 SHALL register the granted address and data into a one-entry output stage; write SHALL go to 0 in the cycle after the grant, giving latency 1.
REQ-022 SHALL hold write at 1 in any cycle following a cycle with no grant; writeAdd and in SHALL then hold their last values.
REQ-023 SHALL allow back-to-back grants in consecutive cycles, one register write per cycle at full throughput.
REQ-024 SHALL, with stall=1, still retire an already-registered write in that cycle and issue no new grant.
REQ-025 SHALL set fwd1_hit = (write==0) && (readAdd1==writeAdd); fwd2_hit SHALL be defined likewise for readAdd2.
REQ-026 SHALL NOT merge two requesters that target the same address in the same cycle: the loser waits, and its write lands one cycle later, so the last writer is the later grant.
REQ-027 SHALL treat writes to register 7 identically to writes to every other register; there is no special PC path in this block.

Reset
REQ-028 SHALL, while reset=0, force write=1, writeAdd=0, in=0, rr_ptr=0, req_ready=0, fwd1_hit=0 and fwd2_hit=0.
REQ-029 SHALL discard any registered-but-unretired write when reset asserts mid-operation; it SHALL NOT reach the register file.
REQ-030 SHALL issue its first grant no earlier than the first rising edge after reset deasserts.

Structure
REQ-031 SHALL take DW, AW and the default NREQ from the shared processor package, alongside the register-count constant 8.
REQ-032 SHALL contain one sub-module, rr_arbiter: combinational round-robin pick from req_valid and rr_ptr, returning a one-hot grant; the rr_ptr flop stays in the parent.

Verification
REQ-033 SHALL cover single request: after reset, req_valid=001, addr0=5, data0=0x1234 -> req_ready=001 in cycle 0; write=0, writeAdd=5, in=0x1234 in cycle 1.
REQ-034 SHALL cover round-robin: req_valid=111 held for 4 cycles -> grants 001, 010, 100, 001; writes appear in that order, one per cycle.
REQ-035 SHALL cover forwarding: write pending to R3 with data 0xBEEF, readAdd1=3, readAdd2=4 -> fwd1_hit=1, fwd2_hit=0, fwd_data=0xBEEF.
REQ-036 SHALL cover stall: grant in cycle 0, stall=1 in cycle 1 with req_valid=111 -> cycle 1 write=0 for the old request and req_ready=000; cycle 2 write=1.
REQ-037 SHALL cover reset mid-operation: grant to R6 with data 0xAAAA, reset=0 before the next edge -> write never goes to 0, rr_ptr=0, and the first grant after release goes to requester 0.
REQ-038 SHALL cover same-address conflict: requesters 1 and 2 both target R7 with 0x0001 and 0x0002, rr_ptr=1 -> R7 written 0x0001 then 0x0002, final value 0x0002.
